traffic_phase_scheduler: RTL



---
 rtl/traffic_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/traffic_phase_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state and lamp encodings for the intersection phase scheduler
package traffic_pkg;

    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        S_ALLRED = 3'd0,
        S_GREEN  = 3'd1,
        S_YELLOW = 3'd2,
        S_WALK   = 3'd3,
        S_FLASH  = 3'd4
    } state_t;

    localparam logic [1:0] L_RED    = 2'b00;
    localparam logic [1:0] L_GREEN  = 2'b01;
    localparam logic [1:0] L_YELLOW = 2'b10;
    localparam logic [1:0] L_FLASH  = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first pending index after ptr
module rr_arbiter
    import traffic_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    logic [IDX_W-1:0] start;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;

    // rot[k] is the request k places after the pointer, wrapping
    assign start = (ptr >= IDX_W'(N - 1)) ? '0 : ptr + IDX_W'(1);
    assign dbl   = {pending, pending};
    assign rot   = N'(dbl >> start);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grant = IDX_W'((int'(start) + k) % N);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - round-robin green/yellow/all-red/walk scheduler for N approaches
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int N_APPR      = 4,
    parameter int CNT_W       = 8,
    parameter int T_MIN_GREEN = 10,
    parameter int T_MAX_GREEN = 40,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1,
    parameter int T_WALK      = 6
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  en,
    input  logic [N_APPR-1:0]     req,
    input  logic                  ped_req,
    output logic [2*N_APPR-1:0]   light,
    output logic                  ped_walk,
    output logic [2:0]            cur_appr,
    output logic [2:0]            phase
);

    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(T_WALK - 1);

    state_t                state, state_n;
    logic [CNT_W-1:0]      timer, timer_n;
    logic [IDX_W-1:0]      rr_ptr, ptr_n, idx_n, arb_grant;
    logic [N_APPR-1:0]     pending, pending_n, green_mask, pend_eff, grant_mask;
    logic                  ped_pend, ped_pend_n, last_ped, last_ped_n;
    logic                  ped_eff, other_pend, cur_req, arb_valid, enter_green;
    logic [2*N_APPR-1:0]   light_n;

    // Requests arriving this cycle count toward this cycle's decision
    assign green_mask = (state == S_GREEN) ? (N_APPR'(1) << cur_appr) : '0;
    assign pend_eff   = pending | (req & ~green_mask);
    assign ped_eff    = ped_pend | ped_req;
    assign other_pend = |(pend_eff & ~green_mask);
    assign cur_req    = |(req & green_mask);
    assign grant_mask = N_APPR'(1) << arb_grant;
    assign phase      = state;

    rr_arbiter #(.N(N_APPR)) u_arb (
        .pending (pend_eff),
        .ptr     (rr_ptr),
        .grant   (arb_grant),
        .valid   (arb_valid)
    );

    always_comb begin
        state_n     = state;
        idx_n       = cur_appr;
        ptr_n       = rr_ptr;
        last_ped_n  = last_ped;
        enter_green = 1'b0;
        case (state)
            S_ALLRED: begin
                if (timer >= AR_LAST) begin
                    if (ped_eff && !last_ped) begin
                        state_n = S_WALK;
                    end else if (arb_valid) begin
                        state_n     = S_GREEN;
                        idx_n       = arb_grant;
                        ptr_n       = arb_grant;
                        last_ped_n  = 1'b0;
                        enter_green = 1'b1;
                    end
                end
            end
            S_GREEN: begin
                if (timer >= MIN_LAST && (other_pend || ped_eff) && (!cur_req || timer >= MAX_LAST))
                    state_n = S_YELLOW;
            end
            S_YELLOW: if (timer >= Y_LAST) state_n = S_ALLRED;
            S_WALK: begin
                if (timer >= WALK_LAST) begin
                    state_n    = S_ALLRED;
                    last_ped_n = 1'b1;
                end
            end
            S_FLASH: if (en) state_n = S_ALLRED;
            default: state_n = S_ALLRED;
        endcase

        if (!en) begin
            state_n     = S_FLASH;
            idx_n       = cur_appr;
            ptr_n       = rr_ptr;
            last_ped_n  = last_ped;
            enter_green = 1'b0;
        end

        if (state == S_FLASH || !en) begin
            pending_n  = '0;
            ped_pend_n = 1'b0;
        end else begin
            pending_n  = enter_green ? (pend_eff & ~grant_mask) : pend_eff;
            ped_pend_n = (state_n == S_WALK && state != S_WALK) ? 1'b0 : ped_eff;
        end

        timer_n = (state_n != state) ? '0 : ((&timer) ? timer : timer + CNT_W'(1));

        light_n = '0;
        for (int i = 0; i < N_APPR; i++) begin
            if (state_n == S_FLASH)
                light_n[2*i +: 2] = L_FLASH;
            else if (idx_n == IDX_W'(i) && state_n == S_GREEN)
                light_n[2*i +: 2] = L_GREEN;
            else if (idx_n == IDX_W'(i) && state_n == S_YELLOW)
                light_n[2*i +: 2] = L_YELLOW;
            else
                light_n[2*i +: 2] = L_RED;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state    <= S_ALLRED;
            timer    <= '0;
            rr_ptr   <= IDX_W'(N_APPR - 1);
            pending  <= '0;
            ped_pend <= 1'b0;
            last_ped <= 1'b0;
            cur_appr <= '0;
            light    <= '0;
            ped_walk <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            rr_ptr   <= ptr_n;
            pending  <= pending_n;
            ped_pend <= ped_pend_n;
            last_ped <= last_ped_n;
            cur_appr <= idx_n;
            light    <= light_n;
            ped_walk <= (state_n == S_WALK);
        end
    end

endmodule
